// File: rtl/simple_proc_prog_loader_pkg.sv
// rtl/simple_proc_prog_loader_pkg.sv - shared constants and loader state type
package simple_proc_prog_loader_pkg;

   localparam int          PROG_DEPTH        = 1024;
   localparam int          PROG_ADDR_W       = 10;
   localparam logic [15:0] FILL_WORD_DEFAULT = 16'h0000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_START = 2'd2,
      ST_RUN   = 2'd3
   } loader_state_t;

endpackage

// File: rtl/simple_proc_prog_loader_if.sv
// rtl/simple_proc_prog_loader_if.sv - host write stream and core fetch port bundle
interface simple_proc_prog_loader_if
   import simple_proc_prog_loader_pkg::*;
#(
   parameter int ADDR_W = PROG_ADDR_W
);
   logic [15:0]       host_wr_data;
   logic              host_wr_valid;
   logic              host_wr_last;
   logic              host_wr_ready;
   logic              host_clear;
   logic [ADDR_W-1:0] pc;
   logic              ram_read_en;
   logic [15:0]       data_in;
   logic              data_vld;

   modport master (
      output host_wr_data, host_wr_valid, host_wr_last, host_clear, pc, ram_read_en,
      input  host_wr_ready, data_in, data_vld
   );

   modport slave (
      input  host_wr_data, host_wr_valid, host_wr_last, host_clear, pc, ram_read_en,
      output host_wr_ready, data_in, data_vld
   );
endinterface

// File: rtl/simple_proc_prog_loader_prog_ram.sv
// rtl/simple_proc_prog_loader_prog_ram.sv - program RAM, one write port, registered read port
module prog_ram_1kx16 #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [15:0]       wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [15:0]       rdata
);
   logic [15:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end
endmodule

// File: rtl/simple_proc_prog_loader.sv
// rtl/simple_proc_prog_loader.sv - streams a program into RAM, launches the core, serves fetches
module simple_proc_prog_loader
   import simple_proc_prog_loader_pkg::*;
#(
   parameter int          DEPTH     = PROG_DEPTH,
   parameter int          ADDR_W    = PROG_ADDR_W,
   parameter logic [15:0] FILL_WORD = FILL_WORD_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   simple_proc_prog_loader_if.slave   bus,
   output logic                       start,
   output logic [ADDR_W:0]            prog_len,
   output logic                       loaded,
   output logic                       load_overflow
);
   localparam logic [ADDR_W:0] LAST_PTR = (ADDR_W+1)'(DEPTH - 1);

   loader_state_t   state, state_nxt;
   logic [ADDR_W:0] wr_ptr;
   logic            wr_open, accept, implicit_last, fetch;
   logic [15:0]     ram_q;
   logic            rd_vld, rd_fill, rd_seen;

   assign wr_open       = (state == ST_IDLE) || (state == ST_LOAD);
   assign accept        = bus.host_wr_valid & wr_open & ~bus.host_clear;
   assign implicit_last = (wr_ptr == LAST_PTR) & ~bus.host_wr_last;
   assign fetch         = bus.ram_read_en & (state == ST_RUN) & ~bus.host_clear;

   assign bus.host_wr_ready = wr_open & rst_n;
   assign bus.data_vld      = rd_vld;
   // data_in reads zero until the first fetch so the unreset RAM port never leaks out
   assign bus.data_in       = !rd_seen ? 16'h0000 : (rd_fill ? FILL_WORD : ram_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      loaded    = 1'b0;
      case (state)
         ST_IDLE, ST_LOAD: begin
            if (accept) begin
               state_nxt = (bus.host_wr_last || implicit_last) ? ST_START : ST_LOAD;
            end
         end
         ST_START: begin
            start     = ~bus.host_clear;
            state_nxt = ST_RUN;
         end
         ST_RUN: begin
            loaded = 1'b1;
         end
         default: state_nxt = ST_IDLE;
      endcase
      if (bus.host_clear) begin
         state_nxt = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         prog_len      <= '0;
         load_overflow <= 1'b0;
         rd_vld        <= 1'b0;
         rd_fill       <= 1'b0;
         rd_seen       <= 1'b0;
      end else if (bus.host_clear) begin
         wr_ptr        <= '0;
         prog_len      <= '0;
         load_overflow <= 1'b0;
         rd_vld        <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (implicit_last) begin
               load_overflow <= 1'b1;
            end
         end
         if (state == ST_START) begin
            prog_len <= wr_ptr;
         end
         rd_vld <= fetch;
         if (fetch) begin
            rd_seen <= 1'b1;
            rd_fill <= ({1'b0, bus.pc} >= prog_len);
         end
      end
   end

   prog_ram_1kx16 #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (accept),
      .waddr (wr_ptr[ADDR_W-1:0]),
      .wdata (bus.host_wr_data),
      .re    (fetch),
      .raddr (bus.pc),
      .rdata (ram_q)
   );
endmodule

// File: tb/tb_simple_proc_prog_loader.sv
// tb/tb_simple_proc_prog_loader.sv - randomized self-checking bench for the program loader
module tb_simple_proc_prog_loader;
   import simple_proc_prog_loader_pkg::*;

   localparam logic [15:0] FILL   = 16'hF00D;
   localparam logic [15:0] S_FILL = 16'hBEEF;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   simple_proc_prog_loader_if #(.ADDR_W(10)) bus ();
   simple_proc_prog_loader_if #(.ADDR_W(3))  sbus ();

   logic        start, loaded, load_overflow;
   logic [10:0] prog_len;
   logic        s_start, s_loaded, s_ovf;
   logic [3:0]  s_len;

   simple_proc_prog_loader #(.DEPTH(1024), .ADDR_W(10), .FILL_WORD(FILL)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .start(start), .prog_len(prog_len),
      .loaded(loaded), .load_overflow(load_overflow)
   );

   simple_proc_prog_loader #(.DEPTH(8), .ADDR_W(3), .FILL_WORD(S_FILL)) dut_s (
      .clk(clk), .rst_n(rst_n), .bus(sbus), .start(s_start), .prog_len(s_len),
      .loaded(s_loaded), .load_overflow(s_ovf)
   );

   int total = 0;
   int bad = 0;
   int start_cnt = 0;
   int start_cyc = -1;
   int s_start_cnt = 0;

   always @(posedge clk) begin
      if (start) begin
         start_cnt <= start_cnt + 1;
         start_cyc <= cyc;
      end
      if (s_start) s_start_cnt <= s_start_cnt + 1;
   end

   // reference model: the words the host has loaded since the last clear
   logic [15:0] prog[$];
   logic [15:0] exp_hold = 16'h0000;

   function automatic logic [15:0] model_word(input int a);
      return (a < prog.size()) ? prog[a] : FILL;
   endfunction

   task automatic do_clear();
      bus.host_clear = 1'b1;
      @(negedge clk);
      bus.host_clear = 1'b0;
      prog.delete();
   endtask

   task automatic load_big(input logic [15:0] words[$], input int gap_pct, input bit with_last,
                           output int last_acc);
      int waited;
      last_acc = -1;
      for (int i = 0; i < words.size(); i++) begin
         bus.host_wr_valid = 1'b0;
         while ($urandom_range(0, 99) < gap_pct) @(negedge clk);
         bus.host_wr_data  = words[i];
         bus.host_wr_valid = 1'b1;
         bus.host_wr_last  = with_last && (i == words.size() - 1);
         waited = 0;
         while (bus.host_wr_ready !== 1'b1) begin
            @(negedge clk);
            waited++;
            if (waited > 50) begin
               total++; bad++;
               $display("FAIL load_ready_timeout: got ready=%b want 1", bus.host_wr_ready);
               bus.host_wr_valid = 1'b0;
               return;
            end
         end
         @(negedge clk);
         last_acc = cyc;
         prog.push_back(words[i]);
      end
      bus.host_wr_valid = 1'b0;
      bus.host_wr_last  = 1'b0;
   endtask

   task automatic run_fetches(input int n, input int pc_max);
      logic       en;
      logic [9:0] a;
      for (int k = 0; k < n; k++) begin
         en = ($urandom_range(0, 2) != 0);
         a  = 10'($urandom_range(0, pc_max));
         bus.ram_read_en = en;
         bus.pc          = a;
         @(negedge clk);
         if (en) exp_hold = model_word(int'(a));
         total++;
         if (bus.data_vld !== en) begin
            bad++;
            $display("FAIL fetch_vld pc=%0d: got %b want %b", a, bus.data_vld, en);
         end
         total++;
         if (bus.data_in !== exp_hold) begin
            bad++;
            $display("FAIL fetch_data pc=%0d: got %h want %h", a, bus.data_in, exp_hold);
         end
      end
      bus.ram_read_en = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      total++;
      if ({bus.host_wr_ready, bus.data_vld, start, loaded, load_overflow} !== 5'b0) begin
         bad++;
         $display("FAIL reset_flags: got %b want 00000",
                  {bus.host_wr_ready, bus.data_vld, start, loaded, load_overflow});
      end
      total++;
      if (bus.data_in !== 16'h0 || prog_len !== 11'd0) begin
         bad++;
         $display("FAIL reset_data: got data=%h len=%0d want 0 0", bus.data_in, prog_len);
      end
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (bus.host_wr_ready !== 1'b1 || sbus.host_wr_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_idle_ready: got %b%b want 11", bus.host_wr_ready, sbus.host_wr_ready);
      end
   endtask

   task automatic test_basic_load();
      logic [15:0] w[$];
      int acc;
      int cnt0;
      w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
      cnt0 = start_cnt;
      load_big(w, 0, 1'b1, acc);
      @(negedge clk);
      total++;
      if (start_cnt - cnt0 !== 1 || start_cyc !== acc) begin
         bad++;
         $display("FAIL basic_start: got pulses=%0d cyc=%0d want 1 cyc=%0d",
                  start_cnt - cnt0, start_cyc, acc);
      end
      total++;
      if (prog_len !== 11'd4 || loaded !== 1'b1 || bus.host_wr_ready !== 1'b0) begin
         bad++;
         $display("FAIL basic_run: got len=%0d loaded=%b ready=%b want 4 1 0",
                  prog_len, loaded, bus.host_wr_ready);
      end
   endtask

   task automatic test_fetch_directed();
      bus.ram_read_en = 1'b1; bus.pc = 10'd2;
      @(negedge clk);
      total++;
      if (bus.data_vld !== 1'b1 || bus.data_in !== 16'h3333) begin
         bad++;
         $display("FAIL fetch_pc2: got %b %h want 1 3333", bus.data_vld, bus.data_in);
      end
      bus.pc = 10'd3;
      @(negedge clk);
      total++;
      if (bus.data_vld !== 1'b1 || bus.data_in !== 16'h4444) begin
         bad++;
         $display("FAIL fetch_pc3: got %b %h want 1 4444", bus.data_vld, bus.data_in);
      end
      bus.ram_read_en = 1'b0;
      @(negedge clk);
      total++;
      if (bus.data_vld !== 1'b0 || bus.data_in !== 16'h4444) begin
         bad++;
         $display("FAIL fetch_hold: got %b %h want 0 4444", bus.data_vld, bus.data_in);
      end
      bus.ram_read_en = 1'b1; bus.pc = 10'd9;
      @(negedge clk);
      bus.ram_read_en = 1'b0;
      total++;
      if (bus.data_vld !== 1'b1 || bus.data_in !== FILL) begin
         bad++;
         $display("FAIL fetch_fill: got %b %h want 1 %h", bus.data_vld, bus.data_in, FILL);
      end
      exp_hold = FILL;
      run_fetches(20, 8);
   endtask

   task automatic test_idle_fetch();
      int cnt0;
      do_clear();
      cnt0 = start_cnt;
      for (int k = 0; k < 4; k++) begin
         bus.ram_read_en = 1'b1;
         bus.pc = 10'($urandom_range(0, 7));
         @(negedge clk);
         total++;
         if (bus.data_vld !== 1'b0 || loaded !== 1'b0 || bus.host_wr_ready !== 1'b1
             || bus.data_in !== exp_hold) begin
            bad++;
            $display("FAIL idle_fetch: got vld=%b loaded=%b ready=%b data=%h want 0 0 1 %h",
                     bus.data_vld, loaded, bus.host_wr_ready, bus.data_in, exp_hold);
         end
      end
      bus.ram_read_en = 1'b0;
      total++;
      if (start_cnt !== cnt0 || prog_len !== 11'd0) begin
         bad++;
         $display("FAIL idle_state: got pulses=%0d len=%0d want 0 0", start_cnt - cnt0, prog_len);
      end
   endtask

   task automatic test_clear_mid_load();
      logic [15:0] w[$];
      int acc;
      int cnt0;
      cnt0 = start_cnt;
      w = '{16'hAAA0, 16'hAAA1};
      load_big(w, 0, 1'b0, acc);
      bus.host_wr_data = 16'hAAA2; bus.host_wr_valid = 1'b1; bus.host_wr_last = 1'b0;
      bus.host_clear = 1'b1;
      @(negedge clk);
      bus.host_clear = 1'b0; bus.host_wr_valid = 1'b0;
      prog.delete();
      total++;
      if (prog_len !== 11'd0 || loaded !== 1'b0 || bus.host_wr_ready !== 1'b1) begin
         bad++;
         $display("FAIL clear_load: got len=%0d loaded=%b ready=%b want 0 0 1",
                  prog_len, loaded, bus.host_wr_ready);
      end
      repeat (3) @(negedge clk);
      total++;
      if (start_cnt !== cnt0) begin
         bad++;
         $display("FAIL clear_no_start: got pulses=%0d want 0", start_cnt - cnt0);
      end
      w = '{16'h5A01, 16'h5A02, 16'h5A03};
      load_big(w, 0, 1'b1, acc);
      @(negedge clk);
      total++;
      if (prog_len !== 11'd3 || start_cnt - cnt0 !== 1) begin
         bad++;
         $display("FAIL reload: got len=%0d pulses=%0d want 3 1", prog_len, start_cnt - cnt0);
      end
      run_fetches(16, 5);
   endtask

   task automatic test_random_loads();
      logic [15:0] w[$];
      int acc, len, cnt0;
      for (int it = 0; it < 4; it++) begin
         do_clear();
         w.delete();
         len = $urandom_range(1, 24);
         for (int i = 0; i < len; i++) w.push_back(16'($urandom));
         cnt0 = start_cnt;
         load_big(w, 30, 1'b1, acc);
         @(negedge clk);
         total++;
         if (start_cnt - cnt0 !== 1 || start_cyc !== acc) begin
            bad++;
            $display("FAIL rand_start it=%0d: got pulses=%0d cyc=%0d want 1 cyc=%0d",
                     it, start_cnt - cnt0, start_cyc, acc);
         end
         total++;
         if (prog_len !== 11'(len) || loaded !== 1'b1 || load_overflow !== 1'b0) begin
            bad++;
            $display("FAIL rand_len it=%0d: got len=%0d loaded=%b ovf=%b want %0d 1 0",
                     it, prog_len, loaded, load_overflow, len);
         end
         run_fetches(30, len + 4);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] sw[8];
      logic [15:0] exp;
      for (int i = 0; i < 8; i++) begin
         sw[i] = 16'($urandom);
         sbus.host_wr_data = sw[i]; sbus.host_wr_valid = 1'b1; sbus.host_wr_last = 1'b0;
         total++;
         if (sbus.host_wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL ovf_ready beat=%0d: got %b want 1", i, sbus.host_wr_ready);
         end
         @(negedge clk);
      end
      sbus.host_wr_data = 16'h9999;
      for (int k = 0; k < 3; k++) begin
         total++;
         if (sbus.host_wr_ready !== 1'b0) begin
            bad++;
            $display("FAIL ovf_ninth_ready k=%0d: got %b want 0", k, sbus.host_wr_ready);
         end
         @(negedge clk);
      end
      sbus.host_wr_valid = 1'b0;
      total++;
      if (s_ovf !== 1'b1 || s_len !== 4'd8 || s_loaded !== 1'b1 || s_start_cnt !== 1) begin
         bad++;
         $display("FAIL ovf_state: got ovf=%b len=%0d loaded=%b pulses=%0d want 1 8 1 1",
                  s_ovf, s_len, s_loaded, s_start_cnt);
      end
      for (int a = 0; a < 8; a++) begin
         sbus.ram_read_en = 1'b1; sbus.pc = 3'(a);
         @(negedge clk);
         exp = sw[a];
         total++;
         if (sbus.data_vld !== 1'b1 || sbus.data_in !== exp) begin
            bad++;
            $display("FAIL ovf_fetch pc=%0d: got %b %h want 1 %h", a, sbus.data_vld, sbus.data_in, exp);
         end
      end
      sbus.ram_read_en = 1'b0;
      sbus.host_clear = 1'b1;
      @(negedge clk);
      sbus.host_clear = 1'b0;
      total++;
      if (s_ovf !== 1'b0 || s_len !== 4'd0 || s_loaded !== 1'b0 || sbus.host_wr_ready !== 1'b1) begin
         bad++;
         $display("FAIL ovf_clear: got ovf=%b len=%0d loaded=%b ready=%b want 0 0 0 1",
                  s_ovf, s_len, s_loaded, sbus.host_wr_ready);
      end
   endtask

   task automatic test_reset_mid_run();
      logic [15:0] w[$];
      int acc;
      do_clear();
      w = '{16'hC0DE, 16'hCAFE, 16'hD00D};
      load_big(w, 0, 1'b1, acc);
      @(negedge clk);
      bus.ram_read_en = 1'b1; bus.pc = 10'd1;
      @(posedge clk);
      #1;
      total++;
      if (bus.data_vld !== 1'b1 || bus.data_in !== 16'hCAFE) begin
         bad++;
         $display("FAIL rst_pre_fetch: got %b %h want 1 cafe", bus.data_vld, bus.data_in);
      end
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.data_vld, bus.host_wr_ready, start, loaded, load_overflow} !== 5'b0
          || bus.data_in !== 16'h0 || prog_len !== 11'd0) begin
         bad++;
         $display("FAIL rst_async: got flags=%b data=%h len=%0d want 00000 0000 0",
                  {bus.data_vld, bus.host_wr_ready, start, loaded, load_overflow},
                  bus.data_in, prog_len);
      end
      @(negedge clk);
      rst_n = 1'b1;
      prog.delete();
      exp_hold = 16'h0000;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++;
         if (bus.data_vld !== 1'b0 || bus.host_wr_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_release k=%0d: got vld=%b ready=%b want 0 1",
                     k, bus.data_vld, bus.host_wr_ready);
         end
      end
      bus.ram_read_en = 1'b0;
   endtask

   initial begin
      bus.host_wr_data = '0; bus.host_wr_valid = 1'b0; bus.host_wr_last = 1'b0;
      bus.host_clear = 1'b0; bus.pc = '0; bus.ram_read_en = 1'b0;
      sbus.host_wr_data = '0; sbus.host_wr_valid = 1'b0; sbus.host_wr_last = 1'b0;
      sbus.host_clear = 1'b0; sbus.pc = '0; sbus.ram_read_en = 1'b0;
      test_reset();
      test_basic_load();
      test_fetch_directed();
      test_idle_fetch();
      test_clear_mid_load();
      test_random_loads();
      test_overflow();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish want finish");
      $fatal(1, "timeout");
   end
endmodule
